// File: rtl/sort_run_ctrl.sv
// sort_run_ctrl
// Run sequencer and data-memory arbiter for the single-cycle sorting CPU.
// Loads DEPTH words into data memory, lets the CPU run until it reports done
// (or a cycle budget expires), then streams the memory contents out.
// The single data-memory port is granted to the loader, the CPU or the
// dumper depending on state; outside LOAD/RUN/DUMP the port is idle.
//
// Ports
//   Clk, Clr                  clock, asynchronous active-high reset
//   start                     begin load/run/dump (IDLE, DONE, ERR only)
//   ld_valid/ld_data/ld_ready load stream into memory
//   cpu_run, cpu_done         CPU execute enable / CPU finished
//   cpu_we/cpu_addr/cpu_wdata CPU memory port, honoured only in RUN
//   mem_we/mem_addr/mem_wdata data-memory port; mem_rdata is combinational
//   rd_valid/rd_data/rd_index/rd_ready  dump stream out of memory
//   busy, timeout, cycles     status: active, sticky timeout, RUN cycle count
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting DEPTH load words into memory
// RUN   | CPU owns memory, counting cycles
// DUMP  | streaming memory words out
// DONE  | sequence finished, waiting for start
// ERR   | CPU exceeded its cycle budget, waiting for start
module sort_run_ctrl #(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          cpu_run,
    input  logic          cpu_done,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] rd_index,
    input  logic          rd_ready,
    output logic          busy,
    output logic          timeout,
    output logic [15:0]   cycles
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DUMP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [15:0]   CYC_LAST = 16'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [AW-1:0] idx;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state  <= S_IDLE;
            idx    <= '0;
            cycles <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state <= S_LOAD;
                        idx   <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state  <= S_RUN;
                            cycles <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // The cycle that leaves RUN is itself counted.
                    if (cycles != 16'hFFFF)
                        cycles <= cycles + 16'd1;
                    if (cpu_done) begin
                        state <= S_DUMP;
                        idx   <= '0;
                    end else if (cycles == CYC_LAST) begin
                        state <= S_ERR;
                    end
                end
                S_DUMP: begin
                    if (rd_ready) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_LAST)
                            state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Port mux is purely a function of state so Clr idles the memory port
    // immediately, even in the middle of a write.
    always_comb begin
        ld_ready  = 1'b0;
        cpu_run   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_valid  = 1'b0;
        rd_index  = '0;
        busy      = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_LOAD: begin
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_addr  = idx;
                mem_wdata = ld_data;
                busy      = 1'b1;
            end
            S_RUN: begin
                cpu_run   = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                busy      = 1'b1;
            end
            S_DUMP: begin
                mem_addr = idx;
                rd_valid = 1'b1;
                rd_index = idx;
                busy     = 1'b1;
            end
            S_ERR:   timeout = 1'b1;
            default: ;
        endcase
    end

    assign rd_data = mem_rdata;

endmodule

// File: tb/tb_sort_run_ctrl.sv
// Testbench for sort_run_ctrl: a behavioural data memory plus a reference
// image of what memory should hold (load words, then CPU writes), checked
// against the dump stream, the memory-port mux and the RUN cycle count.
module tb_sort_run_ctrl;

    localparam int DW      = 16;
    localparam int AW      = 4;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 1024;

    logic          Clk = 1'b0;
    logic          Clr;
    logic          start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          cpu_run;
    logic          cpu_done;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_index;
    logic          rd_ready;
    logic          busy;
    logic          timeout;
    logic [15:0]   cycles;

    sort_run_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Clr(Clr), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cpu_run(cpu_run), .cpu_done(cpu_done), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index),
        .rd_ready(rd_ready),
        .busy(busy), .timeout(timeout), .cycles(cycles)
    );

    always #5 Clk = ~Clk;

    logic [DW-1:0] tbmem   [16];
    logic [DW-1:0] ref_mem [16];

    always @(posedge Clk) if (mem_we) tbmem[mem_addr] <= mem_wdata;
    assign mem_rdata = tbmem[mem_addr];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("start_ld_ready", 32'(ld_ready), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_timeout_clear", 32'(timeout), 0);
        chk("start_mem_we", 32'(mem_we), 0);
    endtask

    // gaps=0: descending 0x000F..0x0000, ld_valid held high.
    // gaps=1: random words with random idle cycles.
    task automatic load_words(input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < DEPTH && guard < 200) begin
            guard++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                ld_data  = 16'($urandom);
                #1;
                chk("load_idle_we", 32'(mem_we), 0);
                chk("load_idle_ready", 32'(ld_ready), 1);
                tick();
            end else begin
                ld_valid = 1'b1;
                ld_data  = gaps ? 16'($urandom) : 16'(DEPTH - 1 - i);
                ref_mem[i] = ld_data;
                #1;
                chk("load_we", 32'(mem_we), 1);
                chk("load_addr", 32'(mem_addr), 32'(i));
                chk("load_wdata", 32'(mem_wdata), 32'(ld_data));
                chk("load_cpu_run", 32'(cpu_run), 0);
                tick();
                i++;
            end
        end
        ld_valid = 1'b0;
        if (i < DEPTH) chk("load_budget", 32'(i), 32'(DEPTH));
        #1;
        chk("run_after_load", 32'(cpu_run), 1);
        chk("run_ld_ready", 32'(ld_ready), 0);
    endtask

    // Acts as the CPU for done_at RUN cycles (0: never signals done).
    task automatic run_cpu(input int done_at, input bit abcd);
        int exp_cyc;
        for (int c = 1; c <= TIMEOUT; c++) begin
            if (abcd && c == 1) begin
                cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 16'hABCD;
            end else begin
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 4'($urandom_range(0, 15));
                cpu_wdata = 16'($urandom);
            end
            start    = 1'($urandom_range(0, 1));
            cpu_done = (c == done_at);
            #1;
            chk("run_cpu_run", 32'(cpu_run), 1);
            chk("run_mem_we", 32'(mem_we), 32'(cpu_we));
            chk("run_mem_addr", 32'(mem_addr), 32'(cpu_addr));
            chk("run_mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
            chk("run_cycles", 32'(cycles), 32'(c - 1));
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            tick();
            if (c == done_at) break;
        end
        cpu_done = 1'b0;
        cpu_we   = 1'b0;
        start    = 1'b0;
        exp_cyc  = (done_at != 0) ? done_at : TIMEOUT;
        #1;
        chk("run_end_cycles", 32'(cycles), 32'(exp_cyc));
        chk("run_end_cpu_run", 32'(cpu_run), 0);
        chk("run_end_rd_valid", 32'(rd_valid), (done_at != 0) ? 1 : 0);
        chk("run_end_timeout", 32'(timeout), (done_at != 0) ? 0 : 1);
    endtask

    // mode 0: rd_ready toggles (low first); mode 1: random rd_ready.
    task automatic dump(input int mode, input int exp_cyc);
        int k = 0;
        int n = 0;
        while (k < DEPTH && n < 200) begin
            rd_ready  = (mode == 0) ? 1'(n % 2) : 1'($urandom_range(0, 1));
            cpu_we    = 1'b1;
            cpu_addr  = 4'($urandom_range(0, 15));
            cpu_wdata = 16'($urandom);
            cpu_done  = 1'($urandom_range(0, 1));
            #1;
            chk("dump_rd_valid", 32'(rd_valid), 1);
            chk("dump_rd_index", 32'(rd_index), 32'(k));
            chk("dump_rd_data", 32'(rd_data), 32'(ref_mem[k]));
            chk("dump_mem_we", 32'(mem_we), 0);
            chk("dump_cpu_run", 32'(cpu_run), 0);
            tick();
            if (rd_ready) k++;
            n++;
        end
        rd_ready = 1'b0;
        cpu_we   = 1'b0;
        cpu_done = 1'b0;
        chk("dump_count", 32'(k), 32'(DEPTH));
        #1;
        chk("done_rd_valid", 32'(rd_valid), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_timeout", 32'(timeout), 0);
        chk("done_cycles", 32'(cycles), 32'(exp_cyc));
        chk("done_mem_addr", 32'(mem_addr), 0);
    endtask

    initial begin
        int d;
        Clr = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        cpu_done = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tbmem[i] = '0;
            ref_mem[i] = '0;
        end
        #12;
        chk("rst_ld_ready", 32'(ld_ready), 0);
        chk("rst_cpu_run", 32'(cpu_run), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_index", 32'(rd_index), 0);
        chk("rst_rd_data", 32'(rd_data), 32'(tbmem[0]));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_cycles", 32'(cycles), 0);
        tick();
        Clr = 1'b0;
        tick();

        // Descending load, 200-cycle run with directed CPU write, toggled dump.
        do_start();
        load_words(1'b0);
        run_cpu(200, 1'b1);
        dump(0, 200);

        // cpu_done in DONE is ignored.
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        #1;
        chk("done_ignores_cpu_done", 32'(busy), 0);

        // Timeout path, then restart clears the error.
        do_start();
        load_words(1'b1);
        run_cpu(0, 1'b0);
        chk("err_busy", 32'(busy), 0);
        do_start();

        // cpu_done coincident with the timeout condition.
        load_words(1'b1);
        run_cpu(TIMEOUT, 1'b0);
        dump(1, TIMEOUT);

        // Random sequences.
        for (int r = 0; r < 3; r++) begin
            d = int'($urandom_range(1, 400));
            do_start();
            load_words(1'b1);
            run_cpu(d, 1'b0);
            dump(1, d);
        end

        // Clr in the middle of LOAD.
        do_start();
        for (int i = 0; i < 7; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'($urandom);
            tick();
        end
        ld_valid = 1'b1;
        #1;
        chk("clr_pre_addr", 32'(mem_addr), 7);
        chk("clr_pre_we", 32'(mem_we), 1);
        Clr = 1'b1;
        #1;
        chk("clr_mem_we", 32'(mem_we), 0);
        chk("clr_ld_ready", 32'(ld_ready), 0);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_mem_addr", 32'(mem_addr), 0);
        tick();
        Clr = 1'b0;
        ld_valid = 1'b0;
        tick();
        #1;
        chk("clr_idle_ready", 32'(ld_ready), 0);
        do_start();
        load_words(1'b0);
        run_cpu(5, 1'b0);
        dump(0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
